// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache between a 10-bit CPU word port
// and a two-word (20-bit) RAM block port using a mem_req/mem_ready handshake.
module dm_cache_ctrl #(
    parameter int LINES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [9:0]  cpu_addr,
    input  logic [9:0]  cpu_wdata,
    output logic        cpu_ready,
    output logic        cpu_done,
    output logic [9:0]  cpu_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [9:0]  mem_addr,
    output logic [19:0] mem_wdata,
    input  logic [19:0] mem_rdata,
    input  logic        mem_ready,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 9 - IDX_W;

    typedef enum logic [2:0] {IDLE, COMPARE, MEM_REQ, MEM_WAIT, MEM_DONE} state_t;

    state_t             state_reg;
    logic               we_reg;
    logic [9:0]         addr_reg;
    logic [9:0]         wdata_reg;
    logic               cpu_done_reg;
    logic [9:0]         cpu_rdata_reg;
    logic               mem_we_reg;
    logic [9:0]         mem_addr_reg;
    logic [19:0]        mem_wdata_reg;
    logic [15:0]        hit_count_reg;
    logic [15:0]        miss_count_reg;

    logic [19:0]        data_mem [LINES];
    logic [TAG_W-1:0]   tag_mem [LINES];
    logic               valid_reg [LINES];
    logic [19:0]        line_data_reg;
    logic [TAG_W-1:0]   line_tag_reg;

    logic [IDX_W-1:0]   idx;
    logic [TAG_W-1:0]   tag;
    logic               offset;
    logic               hit;
    logic               line_we;
    logic               fill_en;
    logic [19:0]        line_wdata;

    assign idx    = addr_reg[IDX_W:1];
    assign tag    = addr_reg[9:IDX_W+1];
    assign offset = addr_reg[0];
    assign hit    = valid_reg[idx] && (line_tag_reg == tag);

    // Line writes: a write hit merges one half in COMPARE, a read miss fills in MEM_DONE.
    always_comb begin
        line_we    = 1'b0;
        fill_en    = 1'b0;
        line_wdata = line_data_reg;
        if (!rst && state_reg == COMPARE && we_reg && hit) begin
            line_we = 1'b1;
            if (offset)
                line_wdata[19:10] = wdata_reg;
            else
                line_wdata[9:0] = wdata_reg;
        end
        if (!rst && state_reg == MEM_DONE && mem_ready && !we_reg) begin
            line_we    = 1'b1;
            fill_en    = 1'b1;
            line_wdata = mem_rdata;
        end
    end

    // Data and tag arrays with registered read, fetched as the request is accepted.
    always_ff @(posedge clk) begin
        if (line_we) begin
            data_mem[idx] <= line_wdata;
            tag_mem[idx]  <= tag;
        end
        if (state_reg == IDLE && cpu_req) begin
            line_data_reg <= data_mem[cpu_addr[IDX_W:1]];
            line_tag_reg  <= tag_mem[cpu_addr[IDX_W:1]];
        end
    end

    generate
        for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
            always_ff @(posedge clk) begin
                if (rst)
                    valid_reg[gi] <= 1'b0;
                else if (fill_en && idx == IDX_W'(gi))
                    valid_reg[gi] <= 1'b1;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            cpu_done_reg   <= 1'b0;
            cpu_rdata_reg  <= '0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            hit_count_reg  <= '0;
            miss_count_reg <= '0;
        end else begin
            cpu_done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (cpu_req) begin
                        we_reg    <= cpu_we;
                        addr_reg  <= cpu_addr;
                        wdata_reg <= cpu_wdata;
                        state_reg <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (hit && !we_reg) begin
                        cpu_rdata_reg <= offset ? line_data_reg[19:10] : line_data_reg[9:0];
                        cpu_done_reg  <= 1'b1;
                        if (hit_count_reg != 16'hFFFF)
                            hit_count_reg <= hit_count_reg + 16'd1;
                        state_reg <= IDLE;
                    end else begin
                        if (hit) begin
                            if (hit_count_reg != 16'hFFFF)
                                hit_count_reg <= hit_count_reg + 16'd1;
                        end else if (miss_count_reg != 16'hFFFF) begin
                            miss_count_reg <= miss_count_reg + 16'd1;
                        end
                        // RAM sees address/data combinationally, so these hold until MEM_DONE exits.
                        mem_we_reg    <= we_reg;
                        mem_addr_reg  <= addr_reg;
                        mem_wdata_reg <= {wdata_reg, wdata_reg};
                        state_reg     <= MEM_REQ;
                    end
                end
                MEM_REQ: begin
                    if (mem_ready)
                        state_reg <= MEM_WAIT;
                end
                MEM_WAIT: begin
                    if (!mem_ready)
                        state_reg <= MEM_DONE;
                end
                MEM_DONE: begin
                    if (mem_ready) begin
                        if (!we_reg)
                            cpu_rdata_reg <= mem_addr_reg[0] ? mem_rdata[19:10] : mem_rdata[9:0];
                        cpu_done_reg <= 1'b1;
                        mem_we_reg   <= 1'b0;
                        state_reg    <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign cpu_ready  = (state_reg == IDLE);
    assign cpu_done   = cpu_done_reg;
    assign cpu_rdata  = cpu_rdata_reg;
    assign mem_req    = (state_reg == MEM_REQ) && mem_ready;
    assign mem_we     = mem_we_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_wdata  = mem_wdata_reg;
    assign hit_count  = hit_count_reg;
    assign miss_count = miss_count_reg;
endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Self-checking bench for dm_cache_ctrl: behavioural RAM with configurable latency,
// a directed vector table, plus hand sequences for ignored requests, back-to-back and reset.
module tb_dm_cache_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [9:0]  cpu_addr;
    logic [9:0]  cpu_wdata;
    logic        cpu_ready;
    logic        cpu_done;
    logic [9:0]  cpu_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [19:0] mem_wdata;
    logic [19:0] mem_rdata;
    logic        mem_ready;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dm_cache_ctrl #(.LINES(8)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    // RAM model: combinational block read, busy for ram_lat cycles after each request.
    logic [9:0] ram [1024];
    int         ram_lat = 2;
    int         busy_cnt = 0;

    assign mem_rdata = {ram[{mem_addr[9:1], 1'b1}], ram[{mem_addr[9:1], 1'b0}]};

    always @(posedge clk) begin
        if (mem_req) begin
            mem_ready <= 1'b0;
            busy_cnt  <= ram_lat;
            if (mem_we)
                ram[mem_addr] <= mem_addr[0] ? mem_wdata[19:10] : mem_wdata[9:0];
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1)
                mem_ready <= 1'b1;
        end
    end

    typedef struct packed {
        logic       we;
        logic [9:0] addr;
        logic [9:0] wdata;
        int         lat;
        int         nreq;
        logic [9:0] rdata;
        int         hits;
        int         misses;
    } vec_t;

    vec_t vecs [13];

    logic        cap_we;
    logic [9:0]  cap_addr;
    logic [19:0] cap_wdata;
    logic        ready_at_done;

    function automatic vec_t mk(input logic we, input int addr, input int wdata, input int lat,
                                input int nreq, input int rdata, input int hits, input int misses);
        vec_t v;
        v.we = we; v.addr = 10'(addr); v.wdata = 10'(wdata); v.lat = lat; v.nreq = nreq;
        v.rdata = 10'(rdata); v.hits = hits; v.misses = misses;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Caller is at a negedge; the request is sampled at the following posedge (cycle 0).
    task automatic run_txn(input logic we, input logic [9:0] addr, input logic [9:0] wdata,
                           output int lat, output int nreq);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        lat = 0; nreq = 0;
        do begin
            @(negedge clk);
            lat++;
            cpu_req = 1'b0;
            if (mem_req) begin
                nreq++;
                cap_we = mem_we; cap_addr = mem_addr; cap_wdata = mem_wdata;
            end
        end while (!cpu_done && lat < 60);
        ready_at_done = cpu_ready;
    endtask

    initial begin
        int lat, nreq, dones, done_lat;
        for (int i = 0; i < 1024; i++) ram[i] = '0;
        ram[10] = 10'd5;  ram[11] = 10'd3;  ram[26] = 10'd21; ram[27] = 10'd22;
        ram[51] = 10'd13; ram[42] = 10'd17; ram[43] = 10'd19; ram[90] = 10'd33;
        mem_ready = 1'b1;
        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;

        //          we    addr wdata lat nreq rdata hits misses
        vecs[0]  = mk(1'b0, 10,  0,   6,  1,   5,    0,   1);
        vecs[1]  = mk(1'b0, 11,  0,   2,  0,   3,    1,   1);
        vecs[2]  = mk(1'b1, 11,  7,   6,  1,   3,    2,   1);
        vecs[3]  = mk(1'b0, 11,  0,   2,  0,   7,    3,   1);
        vecs[4]  = mk(1'b0, 10,  0,   2,  0,   5,    4,   1);
        vecs[5]  = mk(1'b0, 26,  0,   6,  1,   21,   4,   2);
        vecs[6]  = mk(1'b0, 10,  0,   6,  1,   5,    4,   3);
        vecs[7]  = mk(1'b1, 50,  9,   6,  1,   5,    4,   4);
        vecs[8]  = mk(1'b0, 50,  0,   6,  1,   9,    4,   5);
        vecs[9]  = mk(1'b0, 51,  0,   2,  0,   13,   5,   5);
        vecs[10] = mk(1'b1, 27,  100, 6,  1,   13,   5,   6);
        vecs[11] = mk(1'b0, 10,  0,   2,  0,   5,    6,   6);
        vecs[12] = mk(1'b0, 27,  0,   6,  1,   100,  6,   7);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset cpu_ready", int'(cpu_ready), 1);
        check("reset cpu_done", int'(cpu_done), 0);
        check("reset cpu_rdata", int'(cpu_rdata), 0);
        check("reset mem_req", int'(mem_req), 0);
        check("reset mem_we", int'(mem_we), 0);
        check("reset mem_addr", int'(mem_addr), 0);
        check("reset mem_wdata", int'(mem_wdata), 0);
        check("reset hit_count", int'(hit_count), 0);
        check("reset miss_count", int'(miss_count), 0);

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            run_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, nreq);
            $display("txn %0d: %s addr=%0d wdata=%0d lat=%0d mem_reqs=%0d rdata=%0d hits=%0d misses=%0d",
                     i, vecs[i].we ? "W" : "R", vecs[i].addr, vecs[i].wdata, lat, nreq,
                     cpu_rdata, hit_count, miss_count);
            check($sformatf("v%0d latency", i), lat, vecs[i].lat);
            check($sformatf("v%0d mem_req count", i), nreq, vecs[i].nreq);
            check($sformatf("v%0d cpu_rdata", i), int'(cpu_rdata), int'(vecs[i].rdata));
            check($sformatf("v%0d hit_count", i), int'(hit_count), vecs[i].hits);
            check($sformatf("v%0d miss_count", i), int'(miss_count), vecs[i].misses);
            check($sformatf("v%0d cpu_ready at done", i), int'(ready_at_done), 1);
            if (vecs[i].nreq != 0 && nreq != 0) begin
                check($sformatf("v%0d mem_we", i), int'(cap_we), int'(vecs[i].we));
                check($sformatf("v%0d mem_addr", i), int'(cap_addr), int'(vecs[i].addr));
                check($sformatf("v%0d mem_addr held", i), int'(mem_addr), int'(vecs[i].addr));
                if (vecs[i].we)
                    check($sformatf("v%0d mem_wdata", i), int'(cap_wdata),
                          int'({vecs[i].wdata, vecs[i].wdata}));
            end
        end
        check("ram[11] written", int'(ram[11]), 7);
        check("ram[50] written", int'(ram[50]), 9);
        check("ram[27] written", int'(ram[27]), 100);

        // Request raised while busy must be dropped, not queued.
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'd42;
        lat = 0; nreq = 0; dones = 0; done_lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            lat = c;
            cpu_req = (c == 3);
            if (c == 3) cpu_addr = 10'd11;
            if (mem_req) nreq++;
            if (cpu_done) begin dones++; done_lat = c; end
        end
        $display("ignored-req txn: addr=42 dones=%0d done_lat=%0d mem_reqs=%0d rdata=%0d", dones, done_lat, nreq, cpu_rdata);
        check("ignored done count", dones, 1);
        check("ignored done latency", done_lat, 6);
        check("ignored mem_req count", nreq, 1);
        check("ignored rdata", int'(cpu_rdata), 17);
        check("ignored miss_count", int'(miss_count), 8);
        check("ignored hit_count", int'(hit_count), 6);

        // Back-to-back: new request issued in the cycle cpu_done is high.
        @(negedge clk);
        run_txn(1'b0, 10'd43, 10'd0, lat, nreq);
        $display("b2b txn 1: addr=43 lat=%0d rdata=%0d", lat, cpu_rdata);
        check("b2b first latency", lat, 2);
        check("b2b first rdata", int'(cpu_rdata), 19);
        run_txn(1'b0, 10'd42, 10'd0, lat, nreq);
        $display("b2b txn 2: addr=42 lat=%0d rdata=%0d hits=%0d", lat, cpu_rdata, hit_count);
        check("b2b second latency", lat, 2);
        check("b2b second rdata", int'(cpu_rdata), 17);
        check("b2b hit_count", int'(hit_count), 8);

        // Reset in cycle 3 of a read miss while the RAM is slow.
        ram_lat = 8;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'd90;
        dones = 0;
        repeat (3) begin
            @(negedge clk);
            cpu_req = 1'b0;
            if (cpu_done) dones++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ram_lat = 2;
        $display("reset mid-txn: done=%0d ready=%0d hits=%0d misses=%0d mem_ready=%0d", cpu_done, cpu_ready, hit_count, miss_count, mem_ready);
        check("midrst early done", dones, 0);
        check("midrst cpu_done", int'(cpu_done), 0);
        check("midrst cpu_ready", int'(cpu_ready), 1);
        check("midrst cpu_rdata", int'(cpu_rdata), 0);
        check("midrst hit_count", int'(hit_count), 0);
        check("midrst miss_count", int'(miss_count), 0);
        check("midrst mem_addr", int'(mem_addr), 0);
        check("midrst ram still busy", int'(mem_ready), 0);

        @(negedge clk);
        run_txn(1'b0, 10'd10, 10'd0, lat, nreq);
        $display("post-reset txn: addr=10 lat=%0d mem_reqs=%0d rdata=%0d misses=%0d", lat, nreq, cpu_rdata, miss_count);
        check("postrst latency", lat, 10);
        check("postrst mem_req count", nreq, 1);
        check("postrst rdata", int'(cpu_rdata), 5);
        check("postrst miss_count", int'(miss_count), 1);
        check("postrst hit_count", int'(hit_count), 0);

        @(negedge clk);
        run_txn(1'b0, 10'd90, 10'd0, lat, nreq);
        $display("post-reset txn: addr=90 lat=%0d mem_reqs=%0d rdata=%0d misses=%0d", lat, nreq, cpu_rdata, miss_count);
        check("abandoned line latency", lat, 6);
        check("abandoned line rdata", int'(cpu_rdata), 33);
        check("abandoned line miss_count", int'(miss_count), 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
